// File: rtl/flag_unit.sv
// CPU status flag register with masked ALU update, bus load,
// a LIFO save/restore stack and a branch-condition decoder.
module flag_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       bReset,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       carry_in,
    input  logic                       overflow_in,
    input  logic                       write_enable,
    input  logic [3:0]                 write_mask,
    input  logic                       load_enable,
    input  logic [3:0]                 flags_in,
    input  logic                       push,
    input  logic                       pop,
    input  logic [2:0]                 cond_sel,
    output logic [3:0]                 flags_out,
    output logic                       carry_out,
    output logic                       zero_out,
    output logic                       negative_out,
    output logic                       overflow_out,
    output logic                       cond_true,
    output logic [$clog2(DEPTH+1)-1:0] stack_depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_error
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    logic [3:0]    flags_q, flags_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [3:0]    stack_q [DEPTH];

    logic          full, empty;
    logic          push_ok, pop_ok;
    logic [3:0]    alu_flags;
    logic [AW-1:0] wr_idx, rd_idx;

    assign full    = (depth_q == FULL);
    assign empty   = (depth_q == '0);
    assign push_ok = push && !pop && !full;
    assign pop_ok  = pop && !push && !empty;
    assign wr_idx  = AW'(depth_q);
    assign rd_idx  = AW'(depth_q - DW'(1));

    assign alu_flags = {overflow_in, alu_result[WIDTH-1],
                        (alu_result == '0), carry_in};

    always_comb begin
        flags_d = flags_q;
        depth_d = depth_q;
        err_d   = err_q;
        if ((push && pop) || (push && full) || (pop && empty))
            err_d = 1'b1;
        // Only one source wins; a losing write mask never merges in.
        if (pop_ok)
            flags_d = stack_q[rd_idx];
        else if (load_enable)
            flags_d = flags_in;
        else if (write_enable)
            flags_d = (flags_q & ~write_mask) | (alu_flags & write_mask);
        if (push_ok)
            depth_d = depth_q + DW'(1);
        else if (pop_ok)
            depth_d = depth_q - DW'(1);
    end

    always_ff @(posedge clk or posedge bReset) begin
        if (bReset) begin
            flags_q <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Contents need no reset: an entry is read only after being pushed.
    always_ff @(posedge clk) begin
        if (push_ok)
            stack_q[wr_idx] <= flags_q;
    end

    always_comb begin
        cond_true = 1'b1;
        unique case (cond_sel)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = flags_q[0];
            3'd2: cond_true = flags_q[1];
            3'd3: cond_true = flags_q[2];
            3'd4: cond_true = flags_q[3];
            3'd5: cond_true = !flags_q[0];
            3'd6: cond_true = !flags_q[1];
            3'd7: cond_true = flags_q[2] ^ flags_q[3];
        endcase
    end

    assign flags_out    = flags_q;
    assign carry_out    = flags_q[0];
    assign zero_out     = flags_q[1];
    assign negative_out = flags_q[2];
    assign overflow_out = flags_q[3];
    assign stack_depth  = depth_q;
    assign stack_full   = full;
    assign stack_empty  = empty;
    assign stack_error  = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: a reference model queues the
// expected state per cycle; directed checks follow the test plan.
module tb_flag_unit;

    logic       clk = 1'b0;
    logic       bReset;
    logic [7:0] alu_result;
    logic       carry_in, overflow_in;
    logic       write_enable, load_enable;
    logic [3:0] write_mask, flags_in;
    logic       push, pop;
    logic [2:0] cond_sel;
    logic [3:0] flags_out;
    logic       carry_out, zero_out, negative_out, overflow_out;
    logic       cond_true;
    logic [2:0] stack_depth;
    logic       stack_full, stack_empty, stack_error;

    flag_unit #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .bReset(bReset),
        .alu_result(alu_result), .carry_in(carry_in),
        .overflow_in(overflow_in), .write_enable(write_enable),
        .write_mask(write_mask), .load_enable(load_enable),
        .flags_in(flags_in), .push(push), .pop(pop),
        .cond_sel(cond_sel), .flags_out(flags_out),
        .carry_out(carry_out), .zero_out(zero_out),
        .negative_out(negative_out), .overflow_out(overflow_out),
        .cond_true(cond_true), .stack_depth(stack_depth),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_error(stack_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] f;
        int         d;
        logic       e;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] m_flags;
    int         m_depth;
    logic       m_err;
    logic [3:0] m_stack [4];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_ref(input logic [2:0] s,
                                      input logic [3:0] f);
        case (s)
            3'd0: return 1'b1;
            3'd1: return f[0];
            3'd2: return f[1];
            3'd3: return f[2];
            3'd4: return f[3];
            3'd5: return ~f[0];
            3'd6: return ~f[1];
            default: return f[2] ^ f[3];
        endcase
    endfunction

    task automatic idle_inputs();
        write_enable = 0; write_mask = 0; load_enable = 0;
        flags_in = 0; push = 0; pop = 0;
        alu_result = 0; carry_in = 0; overflow_in = 0;
    endtask

    task automatic model_reset();
        m_flags = 0; m_depth = 0; m_err = 0;
        sb_q.delete();
    endtask

    task automatic step(input logic we, input logic [3:0] msk,
                        input logic ld, input logic [3:0] fin,
                        input logic ps, input logic pp,
                        input logic [7:0] res, input logic c,
                        input logic v);
        logic [3:0] nxt;
        logic [3:0] alu;
        exp_t       e;
        @(negedge clk);
        write_enable = we; write_mask = msk; load_enable = ld;
        flags_in = fin; push = ps; pop = pp;
        alu_result = res; carry_in = c; overflow_in = v;
        nxt = m_flags;
        if ((ps && pp) || (ps && m_depth == 4) || (pp && m_depth == 0))
            m_err = 1'b1;
        if (pp && !ps && m_depth > 0) begin
            nxt = m_stack[m_depth-1];
            m_depth--;
        end else if (ld) begin
            nxt = fin;
        end else if (we) begin
            alu = {v, res[7], (res == 8'h00), c};
            for (int i = 0; i < 4; i++)
                if (msk[i]) nxt[i] = alu[i];
        end
        if (ps && !pp && m_depth < 4) begin
            m_stack[m_depth] = m_flags;
            m_depth++;
        end
        m_flags = nxt;
        e.f = m_flags; e.d = m_depth; e.e = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("sb_flags", 32'(flags_out), 32'(e.f));
            check("sb_bits", {carry_out, zero_out, negative_out,
                  overflow_out}, {e.f[0], e.f[1], e.f[2], e.f[3]});
            check("sb_depth", 32'(stack_depth), 32'(e.d));
            check("sb_err", 32'(stack_error), 32'(e.e));
            check("sb_full", 32'(stack_full), 32'(e.d == 4));
            check("sb_emp", 32'(stack_empty), 32'(e.d == 0));
        end
    endtask

    task automatic wr(input logic [3:0] msk, input logic [7:0] res,
                      input logic c, input logic v);
        step(1, msk, 0, 0, 0, 0, res, c, v);
    endtask

    task automatic ld(input logic [3:0] f, input logic ps);
        step(0, 0, 1, f, ps, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        bReset = 1;
        model_reset();
        @(negedge clk);
        bReset = 0;
    endtask

    initial begin
        idle_inputs();
        cond_sel = 0;
        bReset = 1;
        model_reset();
        #1;
        check("rst0_flags", 32'(flags_out), 0);
        check("rst0_empty", 32'(stack_empty), 1);
        @(negedge clk);
        bReset = 0;

        // Masked ALU writes, including a null mask.
        wr(4'b0101, 8'h80, 1, 1);
        check("mw1", 32'(flags_out), 32'b0101);
        wr(4'b0010, 8'h00, 0, 0);
        check("mw2", 32'(flags_out), 32'b0111);
        wr(4'b0000, 8'h80, 0, 1);
        check("mw_nop", 32'(flags_out), 32'b0111);
        wr(4'b1111, 8'h7f, 0, 1);
        check("mw_all", 32'(flags_out), 32'b1000);

        // Priority: legal pop beats load beats write.
        ld(4'b0011, 0);
        ld(4'b0110, 1);
        step(1, 4'b1111, 1, 4'b1010, 0, 1, 8'h00, 1, 1);
        check("pri_pop", 32'(flags_out), 32'b0011);
        check("pri_dep", 32'(stack_depth), 0);
        step(1, 4'b1111, 1, 4'b1010, 0, 1, 8'h00, 1, 1);
        check("pri_ld", 32'(flags_out), 32'b1010);
        check("pri_err", 32'(stack_error), 1);

        // Asynchronous mid-cycle reset with a populated stack.
        ld(4'b1111, 0);
        ld(4'b1111, 1);
        ld(4'b1111, 1);
        check("pre_rst_dep", 32'(stack_depth), 2);
        #2;
        bReset = 1;
        idle_inputs();
        #1;
        check("arst_flags", 32'(flags_out), 0);
        check("arst_dep", 32'(stack_depth), 0);
        check("arst_emp", 32'(stack_empty), 1);
        check("arst_err", 32'(stack_error), 0);
        model_reset();
        @(negedge clk);
        bReset = 0;

        // Fill, overflow, drain.
        ld(4'b0001, 0);
        ld(4'b0010, 1);
        ld(4'b0100, 1);
        ld(4'b1000, 1);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("full", 32'(stack_full), 1);
        check("full_err0", 32'(stack_error), 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("ovf_err", 32'(stack_error), 1);
        check("ovf_dep", 32'(stack_depth), 4);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("pop1", 32'(flags_out), 32'b1000);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("pop2", 32'(flags_out), 32'b0100);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("pop3", 32'(flags_out), 32'b0010);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("pop4", 32'(flags_out), 32'b0001);
        check("drain_emp", 32'(stack_empty), 1);

        // Push and pop together: both ignored, write still applies.
        do_reset();
        ld(4'b0000, 1);
        step(1, 4'b0010, 0, 0, 1, 1, 8'h00, 0, 0);
        check("pp_dep", 32'(stack_depth), 1);
        check("pp_z", 32'(zero_out), 1);
        check("pp_err", 32'(stack_error), 1);

        // Branch conditions over several flag patterns.
        ld(4'b0100, 0);
        cond_sel = 3'd7; #1;
        check("c7_n1v0", 32'(cond_true), 1);
        ld(4'b1100, 0);
        cond_sel = 3'd7; #1;
        check("c7_n1v1", 32'(cond_true), 0);
        cond_sel = 3'd6; #1;
        check("c6_z0", 32'(cond_true), 1);
        foreach (m_stack[k]) begin
            ld(4'(k * 5 + 2), 0);
            for (int s = 0; s < 8; s++) begin
                cond_sel = 3'(s); #1;
                check("cond", 32'(cond_true),
                      32'(cond_ref(3'(s), m_flags)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1);
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Clocked, parametrised successor to the CPU flag register.
- Holds four status flags: C, Z, N and V.
  - Z and N are derived internally from the ALU result.
  - C and V come from the ALU.
- Supports per-flag write masking, a direct load from the bus, and a DEPTH-entry save/restore stack for interrupt/call context.
- Produces a combinational branch-condition output for the control unit.

Parameters:
- WIDTH, 8, ALU result width in bits (≥2).
- DEPTH, 4, flag-stack entries (≥1).

Ports:
- clk  in  1  system clock, rising edge active
- bReset  in  1  asynchronous, active-high reset
- alu_result  in  WIDTH  ALU result; source of Z and N
- carry_in  in  1  ALU carry out
- overflow_in  in  1  ALU signed overflow
- write_enable  in  1  update flags from the ALU, under write_mask
- write_mask  in  4  per-flag update enable; bit0=C, bit1=Z, bit2=N, bit3=V
- load_enable  in  1  load all flags from flags_in
- flags_in  in  4  bus value for load (same bit order)
- push  in  1  save current flags to the stack
- pop  in  1  restore flags from the stack
- cond_sel  in  3  branch condition select
- flags_out  out  4  registered flags {V,N,Z,C}
- carry_out, zero_out, negative_out, overflow_out  out  1 each  individual flag bits
- cond_true  out  1  selected condition evaluates true (combinational)
- stack_depth  out  $clog2(DEPTH+1)  number of valid stack entries
- stack_full, stack_empty  out  1  stack_depth==DEPTH, stack_depth==0
- stack_error  out  1  sticky overflow/underflow/conflict indicator

Behaviour:
- Reset (bReset=1, asynchronous, takes effect immediately):
  - flags_out=0, stack_depth=0, stack_error=0, stack_full=0, stack_empty=1.
  - Stack contents are don't-care.
  - Reset mid-operation discards any push/pop in flight.
- All state updates on the rising edge of clk. Flag latency is 1 cycle: new values are visible the cycle after the enable.
- Flag sources on ALU write:
  - C = carry_in
  - Z = (alu_result == 0)
  - N = alu_result[WIDTH-1]
  - V = overflow_in
  - Only flags whose write_mask bit is 1 change. A mask of 0000 with write_enable=1 is a no-op.
- Flag source priority, highest first: pop (when legal), then load_enable, then write_enable.
  - A lower-priority source in the same cycle is ignored entirely; masks do not merge.
- Push:
  - Stores the pre-edge flags_out at index stack_depth; stack_depth increments.
  - Push plus load or write in the same cycle: the old value is saved, and the flags then update per load/write.
- Pop:
  - flags_out takes the entry at stack_depth-1; stack_depth decrements.
- Error conditions (each sets stack_error):
  - Push when full: ignored, stack unchanged, flags still update from load/write.
  - Pop when empty: ignored, flags update from load/write as if pop were absent.
  - push and pop both high: both ignored, stack_depth unchanged, load/write still applies.
- stack_error is sticky until bReset.
- Stack is LIFO with no wrap-around.
- cond_true is combinational from the registered flags:
  - 0: always 1
  - 1: C
  - 2: Z
  - 3: N
  - 4: V
  - 5: !C
  - 6: !Z
  - 7: N^V (signed less-than)
- Outputs never take X after reset. Undriven stack entries are never presented on flags_out.

Test Plan:
- Reset: assert bReset asynchronously mid-cycle with flags=1111 and depth=2 → flags_out=0000 and stack_depth=0 immediately, stack_empty=1, stack_error=0.
- Masked write, WIDTH=8: alu_result=8'h80, carry_in=1, overflow_in=1, mask=0101 → flags_out={V0,N1,Z0,C1}=0101 next cycle. Then alu_result=0, mask=0010 → flags_out=0111.
- Priority: write_enable, load_enable with flags_in=1010, and a legal pop of entry 0011 all in one cycle → flags_out=0011 and depth decrements. Same stimulus with the stack empty → flags_out=1010 and stack_error=1.
- Stack, DEPTH=4:
  - Push 0001, 0010, 0100, 1000 → stack_full=1.
  - A fifth push → ignored, stack_error=1.
  - Four pops → flags_out sequence 1000, 0100, 0010, 0001, then stack_empty=1.
- Simultaneous push, pop and write (alu_result=0, mask=0010) → stack_depth unchanged, Z=1, stack_error=1.
- Conditions: flags N=1, V=0 → cond_sel=7 gives 1. With N=V=1 → 0. With Z=0, cond_sel=6 → 1. cond_sel=0 → 1 in all cases.
